// File: rtl/mem_arbiter_fsm_if.sv
// Bus bundle between the miss arbiter, the two caches' miss/fill ports and main memory.
// The arbiter takes the master view; the caches and memory model take the slave view.
interface mem_arbiter_fsm_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16,
  parameter int WORDS  = 8
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic              i_miss;
  logic [AWIDTH-1:0] i_addr;
  logic              d_miss;
  logic              d_wr;
  logic [AWIDTH-1:0] d_addr;
  logic [DWIDTH-1:0] d_wdata;
  logic              mem_en;
  logic              mem_wr;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;
  logic              mem_valid;
  logic              fill_we;
  logic              fill_sel;
  logic [IW-1:0]     fill_idx;
  logic [DWIDTH-1:0] fill_data;
  logic              fill_last;
  logic              i_done;
  logic              d_done;
  logic              busy;

  modport master (
    input  i_miss, i_addr, d_miss, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output fill_we, fill_sel, fill_idx, fill_data, fill_last,
    output i_done, d_done, busy
  );

  modport slave (
    output i_miss, i_addr, d_miss, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  fill_we, fill_sel, fill_idx, fill_data, fill_last,
    input  i_done, d_done, busy
  );
endinterface

// File: rtl/mem_arbiter_fsm.sv
// Shares one multi-cycle memory between I-cache misses and D-cache misses/stores:
// block fills are issued back-to-back and returned words are streamed into the owning cache.
module mem_arbiter_fsm #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16,
  parameter int WORDS  = 8
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_fsm_if.master bus
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [AWIDTH-1:0] BASE_MASK = ~AWIDTH'(2 * WORDS - 1);
  localparam logic [IW-1:0]     IC_LAST   = IW'(WORDS - 1);
  localparam logic [IW:0]       RC_LAST   = (IW + 1)'(WORDS - 1);
  localparam logic [IW:0]       RC_FULL   = (IW + 1)'(WORDS);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    FILL,
    DRAIN,
    DONE
  } state_t;

  state_t            state, state_next;
  logic              owner, owner_next;
  logic [AWIDTH-1:0] base, base_next;
  logic [DWIDTH-1:0] wdata_q, wdata_next;
  logic [IW-1:0]     ic, ic_next;
  logic [IW:0]       rc, rc_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      base    <= '0;
      wdata_q <= '0;
      ic      <= '0;
      rc      <= '0;
    end else begin
      state   <= state_next;
      owner   <= owner_next;
      base    <= base_next;
      wdata_q <= wdata_next;
      ic      <= ic_next;
      rc      <= rc_next;
    end
  end

  // rc counts returned words; it is one bit wider so a full block is distinguishable from idx 0.
  always_comb begin
    state_next     = state;
    owner_next     = owner;
    base_next      = base;
    wdata_next     = wdata_q;
    ic_next        = ic;
    rc_next        = rc;
    bus.mem_en     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.fill_we    = 1'b0;
    bus.fill_sel   = 1'b0;
    bus.fill_idx   = '0;
    bus.fill_data  = '0;
    bus.fill_last  = 1'b0;
    bus.i_done     = 1'b0;
    bus.d_done     = 1'b0;

    if ((state == FILL || state == DRAIN) && bus.mem_valid && rc != RC_FULL) begin
      bus.fill_we   = 1'b1;
      bus.fill_sel  = owner;
      bus.fill_idx  = rc[IW-1:0];
      bus.fill_data = bus.mem_rdata;
      bus.fill_last = (rc == RC_LAST);
      rc_next       = rc + 1'b1;
    end

    case (state)
      IDLE: begin
        if (bus.d_wr) begin
          owner_next = 1'b1;
          base_next  = bus.d_addr;
          wdata_next = bus.d_wdata;
          state_next = WRITE;
        end else if (bus.d_miss) begin
          owner_next = 1'b1;
          base_next  = bus.d_addr & BASE_MASK;
          ic_next    = '0;
          rc_next    = '0;
          state_next = FILL;
        end else if (bus.i_miss) begin
          owner_next = 1'b0;
          base_next  = bus.i_addr & BASE_MASK;
          ic_next    = '0;
          rc_next    = '0;
          state_next = FILL;
        end
      end
      WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = base;
        bus.mem_wdata = wdata_q;
        state_next    = DONE;
      end
      FILL: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = base + AWIDTH'({ic, 1'b0});
        ic_next      = ic + 1'b1;
        if (ic == IC_LAST) begin
          state_next = (rc_next == RC_FULL) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (rc_next == RC_FULL) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.i_done = ~owner;
        bus.d_done = owner;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy = (state != IDLE);
endmodule
